// File: rtl/from8bit.sv
// from8bit: byte-stream deserializer reassembling 8/16/32-bit words from an MSB-first byte stream
module from8bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        enb,
   input  logic [7:0]  dataIn,
   input  logic [1:0]  dataS,
   output logic [7:0]  dataOut,
   output logic [15:0] dataOut16,
   output logic [31:0] dataOut32,
   output logic        valid8,
   output logic        valid16,
   output logic        valid32,
   output logic        dropErr
);
   logic [1:0]  cnt;
   logic [1:0]  mode_q;
   logic [23:0] acc;
   logic        chg;
   logic [1:0]  cur;
   logic [1:0]  last;
   logic        done;
   // A mode change restarts the word at byte 0; the reserved mode never completes a word
   always_comb begin
      chg  = dataS != mode_q;
      cur  = chg ? 2'd0 : cnt;
      last = dataS == 2'b00 ? 2'd0 : dataS == 2'b01 ? 2'd1 : 2'd3;
      done = dataS != 2'b11 && cur == last;
   end
   // Byte accumulation, word completion and one-cycle strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 2'd0;
         mode_q    <= 2'b00;
         acc       <= 24'd0;
         dataOut   <= 8'd0;
         dataOut16 <= 16'd0;
         dataOut32 <= 32'd0;
         valid8    <= 1'b0;
         valid16   <= 1'b0;
         valid32   <= 1'b0;
         dropErr   <= 1'b0;
      end else begin
         valid8  <= 1'b0;
         valid16 <= 1'b0;
         valid32 <= 1'b0;
         dropErr <= 1'b0;
         if (enb) begin
            mode_q  <= dataS;
            dropErr <= chg && cnt != 2'd0;
            if (dataS == 2'b11) begin
               cnt <= 2'd0;
            end else if (done) begin
               cnt <= 2'd0;
               if (dataS == 2'b00) begin
                  dataOut <= dataIn;
                  valid8  <= 1'b1;
               end else if (dataS == 2'b01) begin
                  dataOut16 <= {acc[7:0], dataIn};
                  valid16   <= 1'b1;
               end else begin
                  dataOut32 <= {acc[23:0], dataIn};
                  valid32   <= 1'b1;
               end
            end else begin
               cnt <= cur + 2'd1;
               acc <= {(cur == 2'd0 ? 16'd0 : acc[15:0]), dataIn};
            end
         end
      end
   end
endmodule

// File: tb/tb_from8bit.sv
// tb_from8bit: scoreboard bench for the byte-stream deserializer
module tb_from8bit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enb = 1'b0;
   logic [7:0]  dataIn = 8'd0;
   logic [1:0]  dataS = 2'b00;
   logic [7:0]  dataOut;
   logic [15:0] dataOut16;
   logic [31:0] dataOut32;
   logic        valid8, valid16, valid32, dropErr;

   typedef struct packed {
      logic        v8;
      logic        v16;
      logic        v32;
      logic        drop;
      logic [7:0]  d8;
      logic [15:0] d16;
      logic [31:0] d32;
   } resp_t;

   resp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   from8bit dut (
      .clk(clk), .rst(rst), .enb(enb), .dataIn(dataIn), .dataS(dataS),
      .dataOut(dataOut), .dataOut16(dataOut16), .dataOut32(dataOut32),
      .valid8(valid8), .valid16(valid16), .valid32(valid32), .dropErr(dropErr)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [7:0] d, input logic [1:0] s, input logic e);
      @(negedge clk);
      dataIn = d;
      dataS  = s;
      enb    = e;
   endtask

   task automatic expect_resp(input logic v8, input logic v16, input logic v32, input logic drop,
                              input logic [7:0] d8, input logic [15:0] d16, input logic [31:0] d32);
      resp_t r;
      r.v8 = v8; r.v16 = v16; r.v32 = v32; r.drop = drop;
      r.d8 = d8; r.d16 = d16; r.d32 = d32;
      exp_q.push_back(r);
   endtask

   task automatic check_zero(input string name);
      resp_t act;
      act = {valid8, valid16, valid32, dropErr, dataOut, dataOut16, dataOut32};
      checks++;
      if (act != '0) begin
         errors++;
         $display("FAIL %s: got %h, want all zero", name, act);
      end
   endtask

   // Monitor: any strobe pops one expected response and compares every output
   always @(negedge clk) begin
      resp_t act;
      resp_t want;
      if (rst && (valid8 || valid16 || valid32 || dropErr)) begin
         act = {valid8, valid16, valid32, dropErr, dataOut, dataOut16, dataOut32};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: got v8=%b v16=%b v32=%b drop=%b, want no strobe",
                     valid8, valid16, valid32, dropErr);
         end else begin
            want = exp_q.pop_front();
            if (act != want) begin
               errors++;
               $display("FAIL word: got v8=%b v16=%b v32=%b drop=%b d8=%h d16=%h d32=%h, want v8=%b v16=%b v32=%b drop=%b d8=%h d16=%h d32=%h",
                        act.v8, act.v16, act.v32, act.drop, act.d8, act.d16, act.d32,
                        want.v8, want.v16, want.v32, want.drop, want.d8, want.d16, want.d32);
            end
         end
      end
   end

   initial begin
      logic [7:0] t1 [6];
      t1 = '{8'hff, 8'hf0, 8'h0f, 8'h00, 8'h80, 8'h01};
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b1;
      // 8-bit stream
      for (int i = 0; i < 6; i++) begin
         step(t1[i], 2'b00, 1'b1);
         expect_resp(1, 0, 0, 0, t1[i], 16'h0, 32'h0);
      end
      // 16-bit stream
      step(8'had, 2'b01, 1'b1);
      step(8'h43, 2'b01, 1'b1); expect_resp(0, 1, 0, 0, 8'h01, 16'had43, 32'h0);
      step(8'h54, 2'b01, 1'b1);
      step(8'h3f, 2'b01, 1'b1); expect_resp(0, 1, 0, 0, 8'h01, 16'h543f, 32'h0);
      // 32-bit stream
      step(8'h95, 2'b10, 1'b1);
      step(8'hfd, 2'b10, 1'b1);
      step(8'had, 2'b10, 1'b1);
      step(8'h43, 2'b10, 1'b1); expect_resp(0, 0, 1, 0, 8'h01, 16'h543f, 32'h95fdad43);
      step(8'h94, 2'b10, 1'b1);
      step(8'hd5, 2'b10, 1'b1);
      step(8'h54, 2'b10, 1'b1);
      step(8'h3f, 2'b10, 1'b1); expect_resp(0, 0, 1, 0, 8'h01, 16'h543f, 32'h94d5543f);
      // Mid-word switch 32 -> 16 drops the partial word
      step(8'h03, 2'b10, 1'b1);
      step(8'h78, 2'b10, 1'b1);
      step(8'h7d, 2'b01, 1'b1); expect_resp(0, 0, 0, 1, 8'h01, 16'h543f, 32'h94d5543f);
      step(8'h5a, 2'b01, 1'b1); expect_resp(0, 1, 0, 0, 8'h01, 16'h7d5a, 32'h94d5543f);
      // Pause mid-word
      step(8'h12, 2'b01, 1'b1);
      step(8'hee, 2'b01, 1'b0);
      step(8'hee, 2'b10, 1'b0);
      step(8'hee, 2'b00, 1'b0);
      step(8'h34, 2'b01, 1'b1); expect_resp(0, 1, 0, 0, 8'h01, 16'h1234, 32'h94d5543f);
      // Reserved mode ignores the byte; leaving it raises no drop
      step(8'h22, 2'b11, 1'b1);
      step(8'h33, 2'b00, 1'b1); expect_resp(1, 0, 0, 0, 8'h33, 16'h1234, 32'h94d5543f);
      // Switching into 8-bit mid-word: drop and valid8 together
      step(8'h44, 2'b01, 1'b1);
      step(8'h55, 2'b00, 1'b1); expect_resp(1, 0, 0, 1, 8'h55, 16'h1234, 32'h94d5543f);
      // Asynchronous reset mid-word
      step(8'h01, 2'b10, 1'b1);
      step(8'h02, 2'b10, 1'b1);
      step(8'h03, 2'b10, 1'b1);
      step(8'h00, 2'b00, 1'b0);
      #2 rst = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      check_zero("reset_held");
      rst = 1'b1;
      dataIn = 8'haa; dataS = 2'b00; enb = 1'b1;
      expect_resp(1, 0, 0, 0, 8'haa, 16'h0, 32'h0);
      step(8'h00, 2'b00, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_words: got %0d outstanding, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
